// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling and a 3-sample
// majority vote per bit, feeding a small byte FIFO with a pop handshake.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          uartrx,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr,
   output logic                          rx_busy
);

   localparam int DIV = CLKS_PER_BIT / 16;
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;

   localparam logic [TW-1:0] TLAST = TW'(DIV - 1);
   localparam logic [CW-1:0] FULLN = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_HUNT,
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   logic          s1_q;
   logic          rxs_q;
   logic          prev_q;
   state_t        st_q, st_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   logic [1:0]    smp_q, smp_d;
   logic [7:0]    sh_q, sh_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] fcnt_q;
   logic          fe_q, ov_q;

   logic          tick;
   logic          vote;
   logic          full;
   logic          pop;
   logic          push;
   logic          set_fe;
   logic          set_ov;
   logic [3:0]    cur;

   assign tick = (cnt_q == TLAST);
   assign cur  = idx_q + 4'd1;
   assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) |
                 (smp_q[1] & rxs_q);
   assign full = (fcnt_q == FULLN);
   assign pop  = rx_valid & rx_ready;

   assign rx_valid   = (fcnt_q != '0);
   assign rx_data    = mem_q[rp_q];
   assign fifo_count = fcnt_q;
   assign frame_err  = fe_q;
   assign overrun    = ov_q;
   assign rx_busy    = (st_q == S_START) | (st_q == S_DATA) |
                       (st_q == S_STOP);

   // Two-flop synchronizer plus one delay flop for falling-edge detect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q   <= 1'b0;
         rxs_q  <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= uartrx;
         rxs_q  <= s1_q;
         prev_q <= rxs_q;
      end
   end

   // Receiver state, oversample timing, vote samples and shift register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q  <= S_HUNT;
         cnt_q <= '0;
         idx_q <= '0;
         smp_q <= '0;
         sh_q  <= '0;
         bit_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         smp_q <= smp_d;
         sh_q  <= sh_d;
         bit_q <= bit_d;
      end
   end

   // Next-state: ticks count within a bit, vote is resolved at index 9.
   always_comb begin
      st_d   = st_q;
      cnt_d  = tick ? '0 : cnt_q + TW'(1);
      idx_d  = idx_q;
      smp_d  = smp_q;
      sh_d   = sh_q;
      bit_d  = bit_q;
      push   = 1'b0;
      set_fe = 1'b0;
      set_ov = 1'b0;
      if (tick) begin
         idx_d = cur;
         if (cur == 4'd7) smp_d[0] = rxs_q;
         if (cur == 4'd8) smp_d[1] = rxs_q;
      end
      unique case (st_q)
         S_HUNT: begin
            if (rxs_q) st_d = S_IDLE;
         end
         S_IDLE: begin
            if (prev_q & ~rxs_q) begin
               st_d  = S_START;
               cnt_d = '0;
               idx_d = '0;
            end
         end
         S_START: begin
            if (tick && cur == 4'd9) begin
               if (vote) begin
                  st_d = S_IDLE;
               end else begin
                  st_d  = S_DATA;
                  bit_d = '0;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (cur == 4'd9) begin
                  sh_d  = {vote, sh_q[7:1]};
                  bit_d = bit_q + 4'd1;
               end
               if (cur == 4'd0 && bit_q == 4'd8) st_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick && cur == 4'd9) begin
               if (vote) begin
                  if (!full || pop) push = 1'b1;
                  else              set_ov = 1'b1;
                  st_d = S_IDLE;
               end else begin
                  set_fe = 1'b1;
                  st_d   = S_HUNT;
               end
            end
         end
         default: st_d = S_HUNT;
      endcase
   end

   // Circular byte buffer; a pop and push on a full FIFO both proceed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wp_q   <= '0;
         rp_q   <= '0;
         fcnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wp_q] <= sh_q;
            wp_q        <= wp_q + AW'(1);
         end
         if (pop) rp_q <= rp_q + AW'(1);
         unique case ({push, pop})
            2'b10:   fcnt_q <= fcnt_q + CW'(1);
            2'b01:   fcnt_q <= fcnt_q - CW'(1);
            default: fcnt_q <= fcnt_q;
         endcase
      end
   end

   // Sticky error flags; a new error beats a simultaneous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fe_q <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         fe_q <= set_fe | (fe_q & ~err_clr);
         ov_q <= set_ov | (ov_q & ~err_clr);
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives 8N1 frames into uart_rx_fifo, keeps a queue
// model of the FIFO contents and checks every pop from a monitor.
module tb_uart_rx_fifo;

   localparam int CPB   = 128;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uartrx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic [2:0] fifo_count;
   logic       frame_err;
   logic       overrun;
   logic       err_clr = 1'b0;
   logic       rx_busy;

   int   checks = 0;
   int   failures = 0;
   logic [7:0] exp_q[$];
   bit   exp_fe = 1'b0;
   bit   exp_ov = 1'b0;
   bit   auto_pop = 1'b0;
   bit   pop_en = 1'b0;
   bit   man_ready = 1'b0;

   uart_rx_fifo #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (rst_n),
      .uartrx    (uartrx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .fifo_count(fifo_count),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted pop must match the model's head byte.
   initial begin
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pop_unexpected: got %0h expected none",
                        rx_data);
            end else begin
               chk("pop_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   // Sole driver of rx_ready, updated 2 ns after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (auto_pop) rx_ready = pop_en && ($urandom_range(0, 2) == 0);
         else          rx_ready = man_ready;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Expected outcome of a frame is decided by the receive rules.
   task automatic send_frame(input logic [7:0] b, input int per,
                             input int stop_low);
      @(posedge clk);
      #1;
      pop_en = 1'b1;
      uartrx = 1'b0;
      wait_clks(per);
      for (int i = 0; i < 8; i++) begin
         uartrx = b[i];
         wait_clks(per);
      end
      pop_en = 1'b0;
      if (stop_low > 0) begin
         uartrx = 1'b0;
         wait_clks(per * stop_low);
         uartrx = 1'b1;
         wait_clks(per);
      end else begin
         uartrx = 1'b1;
         wait_clks(per);
      end
      if (stop_low > 0)             exp_fe = 1'b1;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                          exp_ov = 1'b1;
      wait_clks(per);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
      chk({tag, "_valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0)
         chk({tag, "_head"}, {24'd0, rx_data}, {24'd0, exp_q[0]});
      chk({tag, "_ferr"}, 32'(frame_err), 32'(exp_fe));
      chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ov));
      chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, "_count"}, 32'(fifo_count), 32'd0);
      chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
      chk({tag, "_ovr"}, 32'(overrun), 32'd0);
      chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
      chk({tag, "_data"}, {24'd0, rx_data}, 32'd0);
   endtask

   task automatic pop_n(input int n);
      @(posedge clk);
      #1;
      man_ready = 1'b1;
      wait_clks(n);
      man_ready = 1'b0;
      wait_clks(3);
   endtask

   task automatic clear_errs();
      @(posedge clk);
      #1;
      err_clr = 1'b1;
      wait_clks(1);
      err_clr = 1'b0;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      wait_clks(2);
   endtask

   initial begin
      logic [7:0] rb;
      int         per;
      int         sl;
      logic [7:0] fb;

      wait_clks(5);
      check_reset_vals("reset");
      rst_n = 1'b1;
      wait_clks(20);

      send_frame(8'h3A, CPB, 0);
      send_frame(8'h57, CPB, 0);
      check_state("b2b");
      pop_n(1);
      check_state("b2b_pop");
      pop_n(1);
      check_state("b2b_empty");

      uartrx = 1'b0;
      wait_clks(24);
      uartrx = 1'b1;
      wait_clks(300);
      check_state("glitch");

      send_frame(8'h68, CPB, 2);
      send_frame(8'h4E, CPB, 0);
      check_state("ferr");
      clear_errs();
      check_state("ferr_clr");
      pop_n(1);

      for (int i = 1; i <= 5; i++) send_frame(8'(i), CPB, 0);
      check_state("ovr");
      pop_n(4);
      clear_errs();
      check_state("ovr_clr");

      for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), CPB, 0);
      check_state("full");
      fork
         send_frame(8'h05, CPB, 0);
         begin
            @(posedge clk);
            #1;
            wait_clks(1226);
            man_ready = 1'b1;
            wait_clks(1);
            man_ready = 1'b0;
         end
      join
      check_state("simul");
      pop_n(4);
      check_state("simul_drain");

      send_frame(8'h99, CPB, 0);
      fb = 8'h3A;
      @(posedge clk);
      #1;
      uartrx = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         uartrx = fb[i];
         if (i == 4) begin
            wait_clks(CPB / 2);
            rst_n = 1'b0;
            exp_q.delete();
            exp_fe = 1'b0;
            exp_ov = 1'b0;
            wait_clks(2);
            check_reset_vals("rst_in");
            wait_clks(CPB / 2 - 2);
         end else if (i == 6) begin
            wait_clks(CPB / 2);
            rst_n = 1'b1;
            wait_clks(CPB / 2);
         end else begin
            wait_clks(CPB);
         end
      end
      uartrx = 1'b1;
      wait_clks(2 * CPB);
      check_reset_vals("rst_after");
      send_frame(8'h57, CPB, 0);
      check_state("rst_next");
      pop_n(1);

      auto_pop = 1'b1;
      for (int n = 0; n < 16; n++) begin
         rb  = 8'($urandom_range(0, 255));
         per = CPB - 3 + int'($urandom_range(0, 6));
         sl  = ($urandom_range(0, 7) == 0) ? 1 : 0;
         send_frame(rb, per, sl);
         check_state("rand");
         if (exp_fe || exp_ov) clear_errs();
      end
      auto_pop = 1'b0;
      wait_clks(3);
      if (exp_q.size() != 0) pop_n(exp_q.size());
      check_state("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the single-cycle CPU's UART peripheral. It takes the raw `uartrx` pin at 9600 baud from the 100 MHz system clock and recovers 8N1 frames using 16x oversampling with majority voting. Received bytes are buffered in a small FIFO. The CPU's peripheral read logic consumes them through a valid/ready pop interface, and can read sticky error flags.

## Interface
- `CLKS_PER_BIT`, 10416, system clocks per bit (100 MHz / 9600); must be a multiple of 16.
- `FIFO_DEPTH`, 4, FIFO entries; power of two, 2..16.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: reset, **asynchronous, active-low**. `reset = 0` clears all state.
- `uartrx` in 1: asynchronous serial line; idles high.
- `rx_data` out 8: FIFO head byte; valid only while `rx_valid = 1`.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: pop request; a pop occurs on an edge where `rx_valid & rx_ready`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of stored bytes.
- `frame_err` out 1: sticky; a stop bit sampled low.
- `overrun` out 1: sticky; a good byte was dropped because the FIFO was full.
- `err_clr` in 1: one-cycle pulse that clears `frame_err` and `overrun`.
- `rx_busy` out 1: receiver is in START, DATA or STOP.

## Operation
- **Synchronizer:** `uartrx` passes through 2 flops, both reset to 0. The third flop `rx_prev` is used for edge detection. All logic uses the synchronized `rxs`.
- **Oversample tick:** a counter wraps every `CLKS_PER_BIT/16` clocks (651) and emits one-cycle `tick`. The counter is forced to 0 when START is entered. A 4-bit tick index counts ticks within the current bit.
- **Majority vote:** `rxs` is sampled at tick indices 7, 8 and 9. The bit value is the majority of the three and is decided at index 9.
- **FSM states:**
  - **HUNT** (reset state): go to IDLE when `rxs = 1`.
  - **IDLE:** on a falling edge (`rx_prev = 1`, `rxs = 0`), go to START with tick index cleared.
  - **START:**
    - At index 9, a voted 0 goes to DATA with bit count 0.
    - A voted 1 is a glitch: return to IDLE, no flag.
    - At index 15 the tick index wraps.
  - **DATA:**
    - Each voted bit shifts in LSB-first.
    - After the 8th bit completes index 15, go to STOP.
  - **STOP:** at index 9 the vote is taken.
    - Voted 1 with FIFO not full: push the byte, go to IDLE.
    - Voted 1 with FIFO full: drop the byte, set `overrun`, go to IDLE.
    - Voted 0: drop the byte, set `frame_err`, go to HUNT. HUNT covers break conditions and prevents a false start.
- **FIFO:**
  - Circular buffer with read/write pointers of `$clog2(FIFO_DEPTH)` bits that wrap modulo depth.
  - `rx_data` shows the entry at the read pointer combinationally.
  - Pop when empty is ignored.
  - When the FIFO is full, a pop and a push on the same edge both occur. Count is unchanged and `overrun` is not set.
- **Error flags:** if `err_clr` coincides with a new error event, the set wins.

## Timing
- **Reset values:**
  - Outputs: `rx_valid` 0, `fifo_count` 0, `frame_err` 0, `overrun` 0, `rx_busy` 0, `rx_data` 0x00.
  - Internal: FSM in HUNT, synchronizer flops 0.
- **Reset mid-frame:** the partial byte is discarded. After release, the FSM waits in HUNT until the line reads high; a frame already in progress is never decoded.
- **Start detection:** the IDLE to START decision comes 2 clocks after the pin falls (synchronizer delay).
- **Bit sampling:** the mid-bit vote for bit k lands at (16·k + 9)·651 clocks after START entry.
  - START is k = 0, data bits are k = 1..8, STOP is k = 9.
- **Push latency:** the push happens on the edge that takes the STOP vote. `rx_valid` and `fifo_count` update on that same edge.
- **Pop:** takes effect on the edge where `rx_valid & rx_ready`. The next head appears on `rx_data` after that edge.
- **Back-to-back frames:** after IDLE is entered, the next start edge is accepted with no dead time. Since IDLE is entered mid-stop-bit, at least 6 ticks of margin remain.
- **Baud tolerance:** ±3% baud mismatch must decode correctly.

## Test plan
- **Two back-to-back frames, no pops:** send 0x3A then 0x57 (8N1, 10416 clk/bit, 1 idle bit between), `rx_ready = 0`.
  - Expect `fifo_count = 2`, head 0x3A.
  - Pulse `rx_ready` for one cycle: head becomes 0x57, count 1.
- **Glitch rejection:** drive `uartrx` low for 2000 clocks, then high.
  - Expect no push, `rx_busy` back to 0, flags 0.
- **Framing error:** send 0x68 with the stop bit held low for 2 bit times, then high, then send 0x4E.
  - Expect `frame_err = 1` and only 0x4E in the FIFO.
  - Pulse `err_clr`: `frame_err` returns to 0.
- **Overrun:** send 5 frames 0x01..0x05 with `FIFO_DEPTH = 4` and `rx_ready = 0`.
  - Expect count 4, `overrun = 1`, pops return 0x01..0x04.
- **Full FIFO with simultaneous pop:** FIFO full, assert `rx_ready` on the STOP-vote edge of a 5th frame.
  - Expect count stays 4, `overrun = 0`, 0x05 at the tail.
- **Reset mid-frame:** assert `reset = 0` during data bit 4 of 0x3A and release it mid-frame.
  - Expect no byte from that frame, all outputs at reset values.
  - The next full frame 0x57 is received correctly.
